// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the ID-stage immediate controller:
//   - ExtOp encodings (how the immediate is extended)
//   - major opcode constants of interest to the immediate decoder
//   - skid-buffer state encoding
//   - the entry record held by each buffer slot
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_BR    = 2'b10,
        EXT_STORE = 2'b11
    } ext_op_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } buf_state_t;

    // One buffered instruction, already decoded at the push side.
    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  ext_op;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{imm: 32'd0, ext_op: 2'b00, pc: 32'd0, illegal: 1'b0};

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate decoder. Selects the ExtOp from the major
// opcode and produces the matching 32-bit extended immediate.
//
// Ports:
//   instr   in  32  raw instruction word
//   ext_op  out  2  ExtOp encoding (riscv_pkg::ext_op_t values)
//   imm     out 32  extended immediate
//   illegal out  1  opcode not recognised by this decoder
//
// Build option: IMM_BTYPE_EN -- when defined, branch opcodes decode to the
// B-format immediate; otherwise they are reported illegal.
// ---------------------------------------------------------------------------
module imm_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [1:0]  ext_op,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [6:0] opcode;
    // Bits 19:12 carry no immediate information for any handled format.
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign unused_bits = ^instr[19:12];

    always_comb begin
        ext_op  = EXT_ZERO;
        imm     = 32'd0;
        illegal = 1'b0;
        case (opcode)
            OPC_STORE: begin
                ext_op = EXT_STORE;
                imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                ext_op = EXT_SIGN;
                imm    = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OP: begin
                ext_op = EXT_ZERO;
                imm    = {20'd0, instr[31:20]};
            end
`ifdef IMM_BTYPE_EN
            OPC_BRANCH: begin
                ext_op = EXT_BR;
                imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            end
`endif
            default: begin
                ext_op  = EXT_ZERO;
                imm     = 32'd0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_imm_ctrl.sv
// ---------------------------------------------------------------------------
// id_imm_ctrl
// ID-stage immediate controller: decodes the immediate of each incoming
// instruction and holds up to two decoded entries in a skid buffer between
// the IF/ID and ID/EX handshakes.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready, instr_in[31:0], pc_in[31:0]   upstream handshake
//   flush           discard every held entry (beats push and pop)
//   out_valid/out_ready                              downstream handshake
//   imm_out[31:0], ext_op_out[1:0], pc_out[31:0], illegal_out   head entry
//
// All outputs come straight from registers; in_ready is a function of the
// buffer state only, so there is no combinational in->out path.
//
// Build option: IMM_BTYPE_EN (consumed by imm_decode) enables B-format
// immediates for branch opcodes.
// ---------------------------------------------------------------------------
module id_imm_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] imm_out,
    output logic [1:0]  ext_op_out,
    output logic [31:0] pc_out,
    output logic        illegal_out
);

    buf_state_t  state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;

    logic [1:0]  dec_ext_op;
    logic [31:0] dec_imm;
    logic        dec_illegal;
    entry_t      new_entry;
    logic        push;
    logic        pop;

    imm_decode u_imm_decode (
        .instr   (instr_in),
        .ext_op  (dec_ext_op),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign new_entry = '{imm: dec_imm, ext_op: dec_ext_op, pc: pc_in, illegal: dec_illegal};

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            // Slot contents are left as-is; out_valid=0 makes them invisible.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Head leaves this cycle, so the newcomer replaces it.
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= ENTRY_RESET;
            tail_q  <= ENTRY_RESET;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign imm_out     = head_q.imm;
    assign ext_op_out  = head_q.ext_op;
    assign pc_out      = head_q.pc;
    assign illegal_out = head_q.illegal;

endmodule

// File: tb/tb_id_imm_ctrl.sv
module tb_id_imm_ctrl;

    typedef struct {
        logic [31:0] imm;
        logic [1:0]  ext_op;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr_in = 32'd0;
    logic [31:0] pc_in = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] imm_out;
    logic [1:0]  ext_op_out;
    logic [31:0] pc_out;
    logic        illegal_out;

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    id_imm_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr_in    (instr_in),
        .pc_in       (pc_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .imm_out     (imm_out),
        .ext_op_out  (ext_op_out),
        .pc_out      (pc_out),
        .illegal_out (illegal_out)
    );

    // Reference decoder built from signed casts rather than bit replication.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        e.illegal = 1'b0;
        case (ins[6:0])
            7'h23: begin e.ext_op = 2'b11; e.imm = 32'($signed({ins[31:25], ins[11:7]})); end
            7'h03, 7'h13, 7'h67: begin e.ext_op = 2'b01; e.imm = 32'($signed(ins[31:20])); end
            7'h33: begin e.ext_op = 2'b00; e.imm = 32'(ins[31:20]); end
`ifdef IMM_BTYPE_EN
            7'h63: begin
                e.ext_op = 2'b10;
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
`endif
            default: begin e.ext_op = 2'b00; e.imm = 32'd0; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_imm"}, imm_out, 32'd0);
        chk({tag, "_ext_op"}, 32'(ext_op_out), 32'd0);
        chk({tag, "_pc"}, pc_out, 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_out), 32'd0);
    endtask

    // One clock cycle: record the handshakes the DUT will see at the coming
    // edge, advance, then compare the head against the scoreboard.
    task automatic step();
        exp_t e;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_pop_on_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", pc_out, e.pc);
                    chk("sb_imm", imm_out, e.imm);
                    chk("sb_ext_op", 32'(ext_op_out), 32'(e.ext_op));
                    chk("sb_illegal", 32'(illegal_out), 32'(e.illegal));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(instr_in, pc_in));
        end
        @(posedge clk);
        @(negedge clk);
        chk("sb_out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        chk("sb_in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        instr_in = ins;
        pc_in = pc;
    endtask

    logic [31:0] instr_tab [8];

    initial begin
        instr_tab[0] = 32'hFFF00093;  // addi -1
        instr_tab[1] = 32'hFE112E23;  // store, offset -4
        instr_tab[2] = 32'h7FF02083;  // load, +2047
        instr_tab[3] = 32'h800000E7;  // jalr, -2048
        instr_tab[4] = 32'hABC00033;  // OP, zero-extended
        instr_tab[5] = 32'hFE000EE3;  // branch
        instr_tab[6] = 32'h0000007F;  // unknown opcode
        instr_tab[7] = 32'h00512023;  // store, +0

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;

        // addi -1, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'h100);
        step();
        drive(1'b0, 32'd0, 32'd0);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_imm", imm_out, 32'hFFFFFFFF);
        chk("addi_ext", 32'(ext_op_out), 32'd1);
        chk("addi_pc", pc_out, 32'h100);
        step();

        // Store
        drive(1'b1, 32'hFE112E23, 32'h104);
        step();
        drive(1'b0, 32'd0, 32'd0);
        chk("store_imm", imm_out, 32'hFFFFFFFC);
        chk("store_ext", 32'(ext_op_out), 32'd3);
        step();

        // Three pushes with out_ready low: third held upstream
        out_ready = 1'b0;
        drive(1'b1, instr_tab[2], 32'h200);
        step();
        drive(1'b1, instr_tab[4], 32'h204);
        step();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, instr_tab[3], 32'h208);
        step();
        chk("full_hold_pc", pc_out, 32'h200);
        chk("full_hold_imm", imm_out, 32'h000007FF);
        chk("full_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk("drain1_pc", pc_out, 32'h204);
        step();
        chk("drain2_pc", pc_out, 32'h208);
        drive(1'b0, 32'd0, 32'd0);
        step();
        chk("drained", 32'(out_valid), 32'd0);

        // Flush while FULL with a concurrent push
        out_ready = 1'b0;
        drive(1'b1, instr_tab[0], 32'h300);
        step();
        drive(1'b1, instr_tab[1], 32'h304);
        step();
        flush = 1'b1;
        drive(1'b1, instr_tab[7], 32'h308);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("flush_stays_empty", 32'(out_valid), 32'd0);

        // Branch, with and without B-format support
        drive(1'b1, 32'hFE000EE3, 32'h400);
        step();
        drive(1'b0, 32'd0, 32'd0);
`ifdef IMM_BTYPE_EN
        chk("br_imm", imm_out, 32'hFFFFFFFC);
        chk("br_ext", 32'(ext_op_out), 32'd2);
        chk("br_illegal", 32'(illegal_out), 32'd0);
`else
        chk("br_illegal", 32'(illegal_out), 32'd1);
        chk("br_ext", 32'(ext_op_out), 32'd0);
`endif
        step();

        // Unknown opcode
        drive(1'b1, 32'h0000007F, 32'h500);
        step();
        drive(1'b0, 32'd0, 32'd0);
        chk("illegal_flag", 32'(illegal_out), 32'd1);
        step();

        // Random handshake burst
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), instr_tab[$urandom_range(0, 7)], 32'h1000 + 32'(i * 4));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Asynchronous reset mid-burst with the buffer full
        out_ready = 1'b0;
        drive(1'b1, instr_tab[2], 32'h2000);
        step();
        drive(1'b1, instr_tab[3], 32'h2004);
        step();
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, instr_tab[1], 32'h3000);
        step();
        drive(1'b0, 32'd0, 32'd0);
        chk("post_rst_pc", pc_out, 32'h3000);
        chk("post_rst_imm", imm_out, 32'hFFFFFFFC);
        out_ready = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
